// File: rtl/ni_inject_buf_if.sv
// Flit bus between the injection buffer, the dmem transmit port and the router input.
// Latency: none (signal bundle only).
// Backpressure: out_ready stalls the router side; the in_flit side has no backpressure.

`ifndef PKTW
`define PKTW 31
`endif
`ifndef FLOWBH
`define FLOWBH 31
`endif
`ifndef FLOWBL
`define FLOWBL 30
`endif

interface ni_inject_buf_if;
    logic [`PKTW:0] in_flit;
    logic [`PKTW:0] out_flit;
    logic           out_valid;
    logic           out_ready;

    // Buffer side: consumes in_flit, presents out_flit to the router.
    modport slave (
        input  in_flit,
        input  out_ready,
        output out_flit,
        output out_valid
    );

    // Environment side: dmem drives in_flit, router drives out_ready.
    modport master (
        output in_flit,
        output out_ready,
        input  out_flit,
        input  out_valid
    );
endinterface

// File: rtl/ni_inject_buf.sv
// Injection buffer: queues the dmem flit stream, checks HEAD/BODY/TAIL framing, counts sent packets.
// Latency: a flit pushed at edge N is on out_flit after edge N (no bypass); 1 push + 1 pop per cycle.
// Backpressure: out_ready stalls the output; input never stalls, so flits arriving at a full FIFO are dropped (ovf).
// Optional INJ_STORE_FWD_EN: hold a HEAD at the output until its whole packet is buffered.

`ifndef PKTW
`define PKTW 31
`endif
`ifndef FLOWBH
`define FLOWBH 31
`endif
`ifndef FLOWBL
`define FLOWBL 30
`endif

module ni_inject_buf #(
    parameter int PU_NUM = 0,
    parameter int DEPTH  = 16
) (
    input  logic            clk,
    input  logic            rst,
    ni_inject_buf_if.slave  bus,
    output logic            ovf,
    output logic            err,
    output logic [15:0]     pkt_cnt,
    output logic            busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] FL_IDLE = 2'd0;
    localparam logic [1:0] FL_HEAD = 2'd1;
    localparam logic [1:0] FL_BODY = 2'd2;
    localparam logic [1:0] FL_TAIL = 2'd3;

    // Pointer wrap relies on a power-of-two depth.
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ni_inject_buf PU%0d: DEPTH %0d must be a power of two >= 4", PU_NUM, DEPTH);
    end

    typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

    state_t         state_q;
    state_t         state_d;
    logic [`PKTW:0] mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [1:0]     in_flow;
    logic [1:0]     head_flow;
    logic           accept;
    logic           frame_err;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic           drop;

    assign in_flow   = bus.in_flit[`FLOWBH:`FLOWBL];
    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign pop       = bus.out_valid && bus.out_ready;
    // A pop in the same cycle frees the slot, so full only blocks when nothing leaves.
    assign push      = accept && (!full || pop);
    assign drop      = accept && full && !pop;

    // Masking with empty keeps out_flit at zero in reset and when idle.
    assign bus.out_flit = empty ? '0 : mem[rd_ptr];
    assign head_flow    = bus.out_flit[`FLOWBH:`FLOWBL];

    assign busy = !empty || (state_q == IN_PKT);

    // Framing state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Framing next state; dropped (overflow) flits still advance it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_flow == FL_HEAD) state_d = IN_PKT;
            IN_PKT:  if (in_flow == FL_TAIL) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Framing decode: which flits enter the queue and which are violations.
    always_comb begin
        accept    = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            IDLE: begin
                accept    = (in_flow == FL_HEAD);
                frame_err = (in_flow == FL_BODY) || (in_flow == FL_TAIL);
            end
            IN_PKT: begin
                // A HEAD inside a packet is kept: it starts the next packet.
                accept    = (in_flow != FL_IDLE);
                frame_err = (in_flow == FL_HEAD);
            end
            default: ;
        endcase
    end

    // Flit storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.in_flit;
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Sticky error flags and forwarded-packet counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf     <= 1'b0;
            err     <= 1'b0;
            pkt_cnt <= '0;
        end else begin
            if (drop)      ovf <= 1'b1;
            if (frame_err) err <= 1'b1;
            if (pop && head_flow == FL_TAIL) pkt_cnt <= pkt_cnt + 16'd1;
        end
    end

`ifdef INJ_STORE_FWD_EN
    logic [4:0] tails_buf;
    logic       gate;

    // Number of complete packets currently buffered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tails_buf <= '0;
        else      tails_buf <= tails_buf + 5'(push && in_flow == FL_TAIL)
                                         - 5'(pop && head_flow == FL_TAIL);
    end

    // Only a HEAD is held back; a full FIFO without a complete packet releases it,
    // otherwise a packet longer than DEPTH could never leave. The FIFO stays full
    // until that HEAD pops, so out_valid cannot fall without a pop.
    assign gate          = (head_flow == FL_HEAD) && (tails_buf == '0) && !full;
    assign bus.out_valid = !empty && !gate;
`else
    assign bus.out_valid = !empty;
`endif

endmodule
